// File: rtl/legv8_pkg.sv
// Shared types and widths for the LEGv8 front end: fetch FSM states,
// buffered fetch entries and the opcode field helper.
package legv8_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_W   = 11;
  localparam int unsigned DEF_ADDR_W = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STALL
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;

  // LEGv8 primary opcode lives in the top 11 bits of the word
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with synchronous flush; the head is read
// straight from registered storage, so a push into an empty FIFO is not bypassed.
module fetch_fifo
  import legv8_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop & ~empty;
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign head   = mem[rd_ptr];

  // Storage is cleared on reset so head fields read as zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 fetch stage: owns the PC, issues in-order word requests, buffers
// responses for decode and flushes/drops the old stream on a redirect.
module fetch_unit
  import legv8_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                IMEM_REQ_VALID,
  input  logic                IMEM_REQ_READY,
  output logic [ADDR_W-1:0]   IMEM_REQ_ADDR,
  input  logic                IMEM_RSP_VALID,
  input  logic [INSTR_W-1:0]  IMEM_RSP_DATA,
  output logic                INSTR_VALID,
  input  logic                INSTR_READY,
  output logic [INSTR_W-1:0]  INSTR,
  output logic [ADDR_W-1:0]   INSTR_PC,
  output logic [OPCODE_W-1:0] OPCODE,
  input  logic                REDIRECT_VALID,
  input  logic [ADDR_W-1:0]   REDIRECT_PC
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic              req_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  out_nxt;
  logic [CNT_W-1:0]  drop_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  credits_nxt;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign req_fire   = req_valid & IMEM_REQ_READY;
  assign push       = IMEM_RSP_VALID & (drop == '0) & ~REDIRECT_VALID;
  assign pop        = ~fifo_empty & INSTR_READY & ~REDIRECT_VALID;
  assign push_entry = '{instr: IMEM_RSP_DATA, pc: DEF_ADDR_W'(rsp_pc)};

  // Credit accounting on next-cycle values; a redirect turns everything in flight into drops
  always_comb begin
    state_nxt   = state;
    drop_nxt    = drop;
    out_nxt     = outstanding + CNT_W'(req_fire) - CNT_W'(IMEM_RSP_VALID);
    cnt_nxt     = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    if (REDIRECT_VALID) begin
      drop_nxt = out_nxt;
      cnt_nxt  = '0;
    end else if (IMEM_RSP_VALID && (drop != '0)) begin
      drop_nxt = drop - CNT_W'(1);
    end
    credits_nxt = CNT_W'(BUF_DEPTH) - out_nxt - cnt_nxt;
    unique case (state)
      S_IDLE:           state_nxt = S_FETCH;
      S_FETCH, S_STALL: state_nxt = (credits_nxt == '0) ? S_STALL : S_FETCH;
      default:          state_nxt = S_IDLE;
    endcase
  end

  // Request valid is a flop so it never depends on IMEM_REQ_READY
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_valid <= (state_nxt == S_FETCH);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_nxt;
      drop        <= drop_nxt;
      if (REDIRECT_VALID) begin
        pc     <= REDIRECT_PC;
        rsp_pc <= REDIRECT_PC;
      end else begin
        if (req_fire) pc <= pc + ADDR_W'(4);
        if (push)     rsp_pc <= rsp_pc + ADDR_W'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .flush     (REDIRECT_VALID),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign IMEM_REQ_VALID = req_valid;
  assign IMEM_REQ_ADDR  = pc;
  assign INSTR_VALID    = ~fifo_empty;
  assign INSTR          = head.instr;
  assign INSTR_PC       = ADDR_W'(head.pc);
  assign OPCODE         = opcode_of(head.instr);

  assert property (@(posedge CLK) disable iff (RST) !(push && fifo_full && !pop));
  assert property (@(posedge CLK) disable iff (RST) REDIRECT_VALID |-> (REDIRECT_PC[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency and a
// stream-level model of which PCs must be requested and delivered.
module tb_fetch_unit;

  localparam int unsigned BUF_DEPTH = 4;
  localparam logic [63:0] RESET_PC  = 64'h0;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IMEM_REQ_VALID;
  logic        IMEM_REQ_READY;
  logic [63:0] IMEM_REQ_ADDR;
  logic        IMEM_RSP_VALID;
  logic [31:0] IMEM_RSP_DATA;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] INSTR;
  logic [63:0] INSTR_PC;
  logic [10:0] OPCODE;
  logic        REDIRECT_VALID;
  logic [63:0] REDIRECT_PC;

  fetch_unit #(
    .ADDR_W    (64),
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .IMEM_REQ_VALID (IMEM_REQ_VALID),
    .IMEM_REQ_READY (IMEM_REQ_READY),
    .IMEM_REQ_ADDR  (IMEM_REQ_ADDR),
    .IMEM_RSP_VALID (IMEM_RSP_VALID),
    .IMEM_RSP_DATA  (IMEM_RSP_DATA),
    .INSTR_VALID    (INSTR_VALID),
    .INSTR_READY    (INSTR_READY),
    .INSTR          (INSTR),
    .INSTR_PC       (INSTR_PC),
    .OPCODE         (OPCODE),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  logic [63:0] pend_addr[$];
  int unsigned pend_due[$];
  int          buffered;
  int          discard;
  logic [63:0] exp_pc;
  logic [63:0] exp_req;
  int          n_fire;
  int          n_pop;
  logic [63:0] last_fire;
  bit          const_mode;
  int unsigned lat_fix;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (const_mode) return 32'h8B020020;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
  endfunction

  function automatic int unsigned pick_lat();
    if (lat_fix != 0) return lat_fix;
    return $urandom_range(4, 1);
  endfunction

  // One clock: resolve this edge's handshakes in the model, advance, then compare
  task automatic step();
    logic        fire;
    logic        pop;
    logic        redir;
    logic        rsp;
    logic [63:0] raddr;
    logic [31:0] w;
    logic [10:0] wop;
    fire  = IMEM_REQ_VALID && IMEM_REQ_READY;
    pop   = INSTR_VALID && INSTR_READY;
    redir = REDIRECT_VALID;
    rsp   = (pend_due.size() > 0) && (pend_due[0] <= cyc + 1);
    if (rsp) begin
      raddr = pend_addr.pop_front();
      void'(pend_due.pop_front());
      IMEM_RSP_VALID = 1'b1;
      IMEM_RSP_DATA  = mem_word(raddr);
    end else begin
      IMEM_RSP_VALID = 1'b0;
      IMEM_RSP_DATA  = $urandom();
    end
    if (IMEM_REQ_VALID) check_eq("req_addr", IMEM_REQ_ADDR, exp_req);
    if (fire) begin
      pend_addr.push_back(IMEM_REQ_ADDR);
      pend_due.push_back(cyc + 1 + pick_lat());
      last_fire = IMEM_REQ_ADDR;
      exp_req   = exp_req + 64'd4;
      n_fire++;
    end
    if (rsp) begin
      if (discard > 0) discard--;
      else if (!redir) buffered++;
    end
    if (pop && !redir) begin
      w   = mem_word(exp_pc);
      wop = w[31:21];
      check_eq("instr_pc", INSTR_PC, exp_pc);
      check_eq("instr", 64'(INSTR), 64'(w));
      check_eq("opcode", 64'(OPCODE), 64'(wop));
      exp_pc = exp_pc + 64'd4;
      if (buffered > 0) buffered--;
      n_pop++;
    end
    if (redir) begin
      buffered = 0;
      discard  = pend_addr.size();
      exp_pc   = REDIRECT_PC;
      exp_req  = REDIRECT_PC;
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    check_eq("instr_valid", 64'(INSTR_VALID), 64'(buffered > 0));
    check_eq("req_valid", 64'(IMEM_REQ_VALID),
             64'((int'(BUF_DEPTH) - pend_addr.size() - buffered) > 0));
  endtask

  task automatic do_reset();
    RST            = 1'b1;
    IMEM_RSP_VALID = 1'b0;
    REDIRECT_VALID = 1'b0;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    check_eq("rst_req_valid", 64'(IMEM_REQ_VALID), 64'd0);
    check_eq("rst_instr_valid", 64'(INSTR_VALID), 64'd0);
    check_eq("rst_instr", 64'(INSTR), 64'd0);
    check_eq("rst_instr_pc", INSTR_PC, 64'd0);
    check_eq("rst_opcode", 64'(OPCODE), 64'd0);
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    pend_addr.delete();
    pend_due.delete();
    buffered = 0;
    discard  = 0;
    exp_pc   = RESET_PC;
    exp_req  = RESET_PC;
    n_fire   = 0;
    RST      = 1'b0;
  endtask

  initial begin
    int          first;
    bit          found;
    logic [63:0] raddr;
    RST = 1'b1; IMEM_REQ_READY = 1'b0; IMEM_RSP_VALID = 1'b0; IMEM_RSP_DATA = '0;
    INSTR_READY = 1'b0; REDIRECT_VALID = 1'b0; REDIRECT_PC = '0;
    n_pop = 0; last_fire = '0; const_mode = 1'b1; lat_fix = 1;
    @(negedge CLK);

    // First fetch latency, opcode decode, then credit stall with no consumer
    do_reset();
    IMEM_REQ_READY = 1'b1;
    first = 0;
    for (int k = 1; k <= 10 && first == 0; k++) begin
      step();
      if (INSTR_VALID) first = k;
    end
    check_eq("t1_latency", 64'(first), 64'd3);
    check_eq("t1_pc", INSTR_PC, 64'h0);
    check_eq("t1_opcode", 64'(OPCODE), 64'h458);
    for (int k = 0; k < 9; k++) step();
    check_eq("t2_fires", 64'(n_fire), 64'd4);
    check_eq("t2_stalled", 64'(IMEM_REQ_VALID), 64'd0);
    n_fire = 0;
    INSTR_READY = 1'b1;
    step();
    INSTR_READY = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check_eq("t2_refill_fires", 64'(n_fire), 64'd1);
    check_eq("t2_refill_addr", last_fire, 64'h10);

    // Memory not ready: address must hold until accepted
    do_reset();
    IMEM_REQ_READY = 1'b0;
    INSTR_READY    = 1'b1;
    step();
    for (int k = 0; k < 5; k++) step();
    check_eq("t3_hold_addr", IMEM_REQ_ADDR, 64'h0);
    check_eq("t3_no_fire", 64'(n_fire), 64'd0);
    IMEM_REQ_READY = 1'b1;
    step();
    check_eq("t3_fired", 64'(n_fire), 64'd1);
    check_eq("t3_next_addr", IMEM_REQ_ADDR, 64'h4);

    // Redirect with two in flight and two buffered
    const_mode = 1'b0;
    lat_fix    = 3;
    do_reset();
    IMEM_REQ_READY = 1'b1;
    INSTR_READY    = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (buffered == 2 && pend_addr.size() == 2) found = 1'b1;
    end
    check_eq("t4_setup", 64'(found), 64'd1);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 64'h400;
    step();
    REDIRECT_VALID = 1'b0;
    check_eq("t4_flushed", 64'(INSTR_VALID), 64'd0);
    INSTR_READY = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (INSTR_VALID) found = 1'b1;
      else step();
    end
    check_eq("t4_delivered", 64'(found), 64'd1);
    check_eq("t4_first_pc", INSTR_PC, 64'h400);
    for (int k = 0; k < 6; k++) step();

    // Redirect on an edge that also accepts a request and returns a response
    lat_fix = 1;
    do_reset();
    IMEM_REQ_READY = 1'b1;
    INSTR_READY    = 1'b1;
    for (int k = 0; k < 6; k++) step();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (IMEM_REQ_VALID && pend_due.size() > 0 && pend_due[0] <= cyc + 1) found = 1'b1;
      else step();
    end
    check_eq("t5_setup", 64'(found), 64'd1);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 64'h800;
    step();
    REDIRECT_VALID = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (INSTR_VALID) found = 1'b1;
      else step();
    end
    check_eq("t5_delivered", 64'(found), 64'd1);
    check_eq("t5_first_pc", INSTR_PC, 64'h800);
    for (int k = 0; k < 8; k++) step();

    // Reset with a full buffer, then restart from RESET_PC
    lat_fix = 2;
    do_reset();
    IMEM_REQ_READY = 1'b1;
    INSTR_READY    = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (buffered == int'(BUF_DEPTH)) found = 1'b1;
    end
    check_eq("t6_full", 64'(found), 64'd1);
    do_reset();
    step();
    check_eq("t6_restart_valid", 64'(IMEM_REQ_VALID), 64'd1);
    check_eq("t6_restart_addr", IMEM_REQ_ADDR, RESET_PC);

    // Random traffic: backpressure, variable latency, redirects incl. wrap, resets
    lat_fix = 0;
    n_pop   = 0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      IMEM_REQ_READY = ($urandom_range(99, 0) < 70);
      INSTR_READY    = ($urandom_range(99, 0) < 60);
      REDIRECT_VALID = ($urandom_range(99, 0) < 3);
      raddr          = {$urandom(), $urandom()};
      raddr[1:0]     = 2'b00;
      if ($urandom_range(7, 0) == 0) raddr = 64'hFFFF_FFFF_FFFF_FFF4;
      REDIRECT_PC = raddr;
      if ($urandom_range(999, 0) < 3) begin
        do_reset();
      end else begin
        step();
      end
    end
    REDIRECT_VALID = 1'b0;
    check_eq("rand_progress", 64'(n_pop > 200), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
